// File: rtl/pcie_h2c_dsc_issuer.sv
// Queues host-to-card transfer requests, issues them on the XDMA H2C descriptor-bypass port and
// counts the returning H2C stream bytes for one completion per descriptor. Option: PCIE_H2C_LEN_CHECK_EN.
module pcie_h2c_dsc_issuer #(
   parameter int          C_DATA_WIDTH    = 256,
   parameter int          REQ_DEPTH       = 8,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [63:0] CARD_DST_ADDR   = 64'h0
) (
   input  logic                        i_user_clk,
   input  logic                        i_user_resetn,
   input  logic                        i_user_lnk_up,
   input  logic                        i_req_valid,
   output logic                        o_req_ready,
   input  logic [63:0]                 i_req_src_addr,
   input  logic [27:0]                 i_req_len,
   input  logic                        i_dsc_byp_ready,
   output logic                        o_dsc_byp_load,
   output logic [63:0]                 o_dsc_byp_src_addr,
   output logic [63:0]                 o_dsc_byp_dst_addr,
   output logic [27:0]                 o_dsc_byp_len,
   output logic [15:0]                 o_dsc_byp_ctl,
   input  logic [C_DATA_WIDTH-1:0]     i_s_axis_tdata,
   input  logic [C_DATA_WIDTH/8-1:0]   i_s_axis_tkeep,
   input  logic                        i_s_axis_tlast,
   input  logic                        i_s_axis_tvalid,
   output logic                        o_s_axis_tready,
   output logic [C_DATA_WIDTH-1:0]     o_m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]   o_m_axis_tkeep,
   output logic                        o_m_axis_tlast,
   output logic                        o_m_axis_tvalid,
   input  logic                        i_m_axis_tready,
   output logic                        o_cpl_valid,
   output logic [27:0]                 o_cpl_bytes,
   output logic                        o_cpl_err,
   output logic [3:0]                  o_inflight
);

   // state | meaning
   // IDLE  | waiting for a queued request, link up and an outstanding slot
   // ARM   | popping the FIFO head into the descriptor registers
   // LOAD  | descriptor presented; load strobes when bypass port is ready
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   localparam int KEEP_W = C_DATA_WIDTH / 8;
   localparam int AW     = $clog2(REQ_DEPTH);

   logic [1:0]    r_state;
   logic [63:0]   r_q_addr [REQ_DEPTH];
   logic [27:0]   r_q_len  [REQ_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [63:0]   r_dsc_src;
   logic [63:0]   r_dsc_dst;
   logic [27:0]   r_dsc_len;
   logic [15:0]   r_dsc_ctl;
   logic [27:0]   r_byte_acc;
   logic          r_cpl_valid;
   logic [27:0]   r_cpl_bytes;
   logic          r_cpl_err;
   logic [3:0]    r_inflight;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_load;
   logic          w_tbeat;
   logic          w_tlast_beat;
   logic [27:0]   w_keep_cnt;
   logic [27:0]   w_tot;
   logic          w_err;

   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push       = i_req_valid && !w_full;
   assign w_load       = (r_state == ST_LOAD) && i_dsc_byp_ready;
   assign w_tbeat      = i_s_axis_tvalid && i_m_axis_tready;
   assign w_tlast_beat = w_tbeat && i_s_axis_tlast;
   assign w_tot        = r_byte_acc + w_keep_cnt;

   // tkeep is contiguous from the LSB, but a plain popcount is just as cheap and tolerant.
   always_comb begin
      w_keep_cnt = '0;
      for (int i = 0; i < KEEP_W; i++)
         w_keep_cnt = w_keep_cnt + 28'(i_s_axis_tkeep[i]);
   end

   assign o_req_ready        = !w_full;
   assign o_dsc_byp_load     = w_load;
   assign o_dsc_byp_src_addr = r_dsc_src;
   assign o_dsc_byp_dst_addr = r_dsc_dst;
   assign o_dsc_byp_len      = r_dsc_len;
   assign o_dsc_byp_ctl      = r_dsc_ctl;
   assign o_s_axis_tready    = i_m_axis_tready;
   assign o_m_axis_tdata     = i_s_axis_tdata;
   assign o_m_axis_tkeep     = i_s_axis_tkeep;
   assign o_m_axis_tlast     = i_s_axis_tlast;
   assign o_m_axis_tvalid    = i_s_axis_tvalid;
   assign o_cpl_valid        = r_cpl_valid;
   assign o_cpl_bytes        = r_cpl_bytes;
   assign o_cpl_err          = r_cpl_err;
   assign o_inflight         = r_inflight;

   always_ff @(posedge i_user_clk) begin
      if (w_push) begin
         r_q_addr[r_wr_ptr[AW-1:0]] <= i_req_src_addr;
         r_q_len[r_wr_ptr[AW-1:0]]  <= i_req_len;
      end
   end

   always_ff @(posedge i_user_clk or negedge i_user_resetn) begin
      if (!i_user_resetn) begin
         r_state   <= ST_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_dsc_src <= '0;
         r_dsc_dst <= '0;
         r_dsc_len <= '0;
         r_dsc_ctl <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty && i_user_lnk_up && (r_inflight < 4'(MAX_OUTSTANDING)))
                  r_state <= ST_ARM;
            end
            ST_ARM: begin
               r_dsc_src <= r_q_addr[r_rd_ptr[AW-1:0]];
               r_dsc_len <= r_q_len[r_rd_ptr[AW-1:0]];
               r_dsc_dst <= CARD_DST_ADDR;
               r_dsc_ctl <= 16'h0010;
               r_rd_ptr  <= r_rd_ptr + 1'b1;
               r_state   <= ST_LOAD;
            end
            ST_LOAD: begin
               // A link drop here does not abandon the descriptor; it waits for ready.
               if (i_dsc_byp_ready)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef PCIE_H2C_LEN_CHECK_EN
   localparam int LW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [27:0]   r_lf_mem [MAX_OUTSTANDING];
   logic [LW-1:0] r_lf_wr;
   logic [LW-1:0] r_lf_rd;
   logic [3:0]    r_lf_cnt;
   logic          w_lf_pop;

   assign w_lf_pop = w_tlast_beat && (r_lf_cnt != 4'd0);
   assign w_err    = (r_lf_cnt == 4'd0) || (w_tot != r_lf_mem[r_lf_rd]);

   always_ff @(posedge i_user_clk) begin
      if (w_load)
         r_lf_mem[r_lf_wr] <= r_dsc_len;
   end

   always_ff @(posedge i_user_clk or negedge i_user_resetn) begin
      if (!i_user_resetn) begin
         r_lf_wr  <= '0;
         r_lf_rd  <= '0;
         r_lf_cnt <= '0;
      end else begin
         if (w_load)
            r_lf_wr <= (r_lf_wr == LW'(MAX_OUTSTANDING - 1)) ? '0 : r_lf_wr + 1'b1;
         if (w_lf_pop)
            r_lf_rd <= (r_lf_rd == LW'(MAX_OUTSTANDING - 1)) ? '0 : r_lf_rd + 1'b1;
         if (w_load && !w_lf_pop)
            r_lf_cnt <= r_lf_cnt + 4'd1;
         else if (w_lf_pop && !w_load)
            r_lf_cnt <= r_lf_cnt - 4'd1;
      end
   end
`else
   assign w_err = (r_inflight == 4'd0);
`endif

   always_ff @(posedge i_user_clk or negedge i_user_resetn) begin
      if (!i_user_resetn) begin
         r_byte_acc  <= '0;
         r_cpl_valid <= 1'b0;
         r_cpl_bytes <= '0;
         r_cpl_err   <= 1'b0;
         r_inflight  <= '0;
      end else begin
         r_cpl_valid <= 1'b0;
         r_cpl_err   <= 1'b0;
         if (w_tlast_beat) begin
            r_cpl_valid <= 1'b1;
            r_cpl_bytes <= w_tot;
            r_cpl_err   <= w_err;
            r_byte_acc  <= '0;
         end else if (w_tbeat) begin
            r_byte_acc  <= w_tot;
         end
         // A stray tlast with nothing outstanding leaves the counter pinned at zero.
         if (w_load && !w_tlast_beat)
            r_inflight <= r_inflight + 4'd1;
         else if (w_tlast_beat && !w_load && (r_inflight != 4'd0))
            r_inflight <= r_inflight - 4'd1;
      end
   end

endmodule

// File: tb/tb_pcie_h2c_dsc_issuer.sv
// Directed bench for pcie_h2c_dsc_issuer (MAX_OUTSTANDING=2); expected cpl_err follows
// whether PCIE_H2C_LEN_CHECK_EN is defined for the build.
module tb_pcie_h2c_dsc_issuer;

   localparam int DW   = 256;
   localparam int KW   = DW / 8;
   localparam logic [31:0] KFULL = 32'hFFFF_FFFF;
`ifdef PCIE_H2C_LEN_CHECK_EN
   localparam logic LEN_CHK = 1'b1;
`else
   localparam logic LEN_CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lnk_up;
   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_src;
   logic [27:0]   req_len;
   logic          byp_ready;
   logic          byp_load;
   logic [63:0]   byp_src;
   logic [63:0]   byp_dst;
   logic [27:0]   byp_len;
   logic [15:0]   byp_ctl;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          s_tlast;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic          cpl_valid;
   logic [27:0]   cpl_bytes;
   logic          cpl_err;
   logic [3:0]    inflight;

   int n_tests = 0;
   int n_fail  = 0;
   int n_load;

   always #5 clk = ~clk;

   pcie_h2c_dsc_issuer #(
      .C_DATA_WIDTH(DW), .REQ_DEPTH(8), .MAX_OUTSTANDING(2), .CARD_DST_ADDR(64'hCAFE_0000)
   ) dut (
      .i_user_clk(clk), .i_user_resetn(rst_n), .i_user_lnk_up(lnk_up),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_src_addr(req_src), .i_req_len(req_len),
      .i_dsc_byp_ready(byp_ready), .o_dsc_byp_load(byp_load),
      .o_dsc_byp_src_addr(byp_src), .o_dsc_byp_dst_addr(byp_dst),
      .o_dsc_byp_len(byp_len), .o_dsc_byp_ctl(byp_ctl),
      .i_s_axis_tdata(s_tdata), .i_s_axis_tkeep(s_tkeep), .i_s_axis_tlast(s_tlast),
      .i_s_axis_tvalid(s_tvalid), .o_s_axis_tready(s_tready),
      .o_m_axis_tdata(m_tdata), .o_m_axis_tkeep(m_tkeep), .o_m_axis_tlast(m_tlast),
      .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
      .o_cpl_valid(cpl_valid), .o_cpl_bytes(cpl_bytes), .o_cpl_err(cpl_err),
      .o_inflight(inflight)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [27:0] l);
      req_valid = 1'b1;
      req_src   = a;
      req_len   = l;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic beat(input logic [31:0] keep, input logic last);
      s_tvalid = 1'b1;
      s_tkeep  = keep;
      s_tlast  = last;
      s_tdata  = {8{$urandom}};
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic chk_cpl(input string tag, input logic [27:0] bytes, input logic err,
                          input logic [3:0] infl);
      chk({tag, "_valid"}, 64'(cpl_valid), 64'd1);
      chk({tag, "_bytes"}, 64'(cpl_bytes), 64'(bytes));
      chk({tag, "_err"},   64'(cpl_err),   64'(err));
      chk({tag, "_infl"},  64'(inflight),  64'(infl));
   endtask

   initial begin
      rst_n = 1'b0; lnk_up = 1'b1; req_valid = 1'b0; req_src = '0; req_len = '0;
      byp_ready = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
      m_tready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_load",      64'(byp_load),  64'd0);
      chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
      chk("rst_cpl_bytes", 64'(cpl_bytes), 64'd0);
      chk("rst_inflight",  64'(inflight),  64'd0);
      chk("rst_src",       byp_src,        64'd0);
      chk("rst_ctl",       64'(byp_ctl),   64'd0);

      // 1: single 4 KiB descriptor, minimum issue latency
      push(64'h1_0000_0000, 28'h1000);
      tick();
      chk("t1_arm_load", 64'(byp_load), 64'd0);
      tick();
      chk("t1_load", 64'(byp_load), 64'd1);
      chk("t1_src",  byp_src, 64'h1_0000_0000);
      chk("t1_dst",  byp_dst, 64'hCAFE_0000);
      chk("t1_len",  64'(byp_len), 64'h1000);
      chk("t1_ctl",  64'(byp_ctl), 64'h0010);
      tick();
      chk("t1_load_once", 64'(byp_load), 64'd0);
      chk("t1_infl", 64'(inflight), 64'd1);
      s_tvalid = 1'b1; s_tkeep = 32'h0000_00FF; s_tdata = {8{32'hA5A5_1234}}; m_tready = 1'b0;
      #1;
      chk("t1_pass_tready", 64'(s_tready), 64'd0);
      chk("t1_pass_tvalid", 64'(m_tvalid), 64'd1);
      chk("t1_pass_tkeep",  64'(m_tkeep),  64'h0000_00FF);
      chk("t1_pass_tdata",  m_tdata[63:0], {2{32'hA5A5_1234}});
      m_tready = 1'b1;
      s_tvalid = 1'b0;
      for (int i = 0; i < 127; i++) beat(KFULL, 1'b0);
      beat(KFULL, 1'b1);
      chk_cpl("t1_cpl", 28'h1000, 1'b0, 4'd0);
      tick();
      chk("t1_cpl_pulse", 64'(cpl_valid), 64'd0);

      // 2: bypass port stalls 10 cycles in LOAD
      byp_ready = 1'b0;
      push(64'h2, 28'h200);
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         chk("t2_stall_load", 64'(byp_load), 64'd0);
         chk("t2_stall_src",  byp_src, 64'h2);
         tick();
      end
      byp_ready = 1'b1;
      #1;
      chk("t2_load_rise", 64'(byp_load), 64'd1);
      chk("t2_len",       64'(byp_len),  64'h200);
      tick();
      chk("t2_load_once", 64'(byp_load), 64'd0);
      chk("t2_infl",      64'(inflight), 64'd1);
      for (int i = 0; i < 15; i++) beat(KFULL, 1'b0);
      beat(KFULL, 1'b1);
      chk_cpl("t2_cpl", 28'h200, 1'b0, 4'd0);

      // 3: outstanding limit of 2 with three queued requests
      push(64'h10, 28'd32);
      push(64'h20, 28'd32);
      push(64'h30, 28'd32);
      n_load = 0;
      for (int i = 0; i < 20; i++) begin
         if (byp_load) n_load++;
         tick();
      end
      chk("t3_loads",    64'(n_load),   64'd2);
      chk("t3_infl",     64'(inflight), 64'd2);
      chk("t3_held_src", byp_src,       64'h20);
      beat(KFULL, 1'b1);
      chk_cpl("t3_cpl1", 28'd32, 1'b0, 4'd1);
      n_load = 0;
      for (int i = 0; i < 6; i++) begin
         if (byp_load) n_load++;
         tick();
      end
      chk("t3_third_load", 64'(n_load),   64'd1);
      chk("t3_third_src",  byp_src,       64'h30);
      chk("t3_infl2",      64'(inflight), 64'd2);
      beat(KFULL, 1'b1);
      beat(KFULL, 1'b1);
      chk_cpl("t3_cpl3", 28'd32, 1'b0, 4'd0);

      // 4: tlast beat coincides with a load; consumer back-pressure stalls the count
      push(64'h40, 28'd64);
      tick(); tick(); tick();
      chk("t4_infl_a", 64'(inflight), 64'd1);
      byp_ready = 1'b0;
      push(64'h50, 28'd64);
      tick(); tick(); tick();
      chk("t4_wait_load", 64'(byp_load), 64'd0);
      s_tvalid = 1'b1; s_tkeep = KFULL; s_tlast = 1'b0; m_tready = 1'b0;
      tick(); tick(); tick();
      m_tready = 1'b1;
      tick();
      s_tlast = 1'b1; byp_ready = 1'b1;
      #1;
      chk("t4_coinc_load", 64'(byp_load), 64'd1);
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      chk_cpl("t4_cpl_a", 28'd64, 1'b0, 4'd1);
      beat(KFULL, 1'b0);
      beat(KFULL, 1'b1);
      chk_cpl("t4_cpl_b", 28'd64, 1'b0, 4'd0);

      // 5: completion shorter than the descriptor, then a stray tlast
      push(64'h60, 28'h100);
      tick(); tick(); tick();
      for (int i = 0; i < 3; i++) beat(32'h0000_FFFF, 1'b0);
      beat(32'h0000_FFFF, 1'b1);
      chk_cpl("t5_short", 28'h40, LEN_CHK, 4'd0);
      beat(KFULL, 1'b1);
      chk_cpl("t5_stray", 28'd32, 1'b1, 4'd0);

      // 6: reset mid-packet, then a fresh packet with a partial last beat
      push(64'h70, 28'h100);
      tick(); tick(); tick();
      beat(KFULL, 1'b0);
      beat(KFULL, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
      chk("t6_rst_infl",      64'(inflight),  64'd0);
      chk("t6_rst_cpl_bytes", 64'(cpl_bytes), 64'd0);
      chk("t6_rst_cpl_err",   64'(cpl_err),   64'd0);
      chk("t6_rst_src",       byp_src,        64'd0);
      chk("t6_rst_len",       64'(byp_len),   64'd0);
      tick();
      rst_n = 1'b1;
      push(64'h80, 28'd36);
      tick(); tick(); tick();
      chk("t6_infl", 64'(inflight), 64'd1);
      beat(KFULL, 1'b0);
      beat(32'h0000_000F, 1'b1);
      chk_cpl("t6_cpl", 28'd36, 1'b0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
